nibble_serial_alu_ctrl: RTL and testbench

Sequencing controller that performs multi-nibble (default 16-bit) unsigned add and subtract by time-multiplexing a single 4-bit ripple adder, one nibble per clock, with a registered inter-nibble carry. It sits between a requesting master (valid/ready operand port) and a result consumer (valid/ready result port). It is the word-width front end for the alu4 datapath, so no wide adder is built.

---
 rtl/alu_ctrl_pkg.sv | 16 +
 rtl/ripple_adder4.sv | 27 ++
 rtl/nibble_serial_alu_ctrl.sv | 148 ++++++++++++++
 tb/tb_nibble_serial_alu_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the nibble-serial ALU controller and its 4-bit adder.
package alu_ctrl_pkg;

    localparam int NIB_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_NEG  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/ripple_adder4.sv
// Plain 4-bit ripple-carry adder; the only arithmetic element of the serial ALU.
module ripple_adder4
    import alu_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a_i,
    input  logic [NIB_W-1:0] b_i,
    input  logic             cin_i,
    output logic [NIB_W-1:0] sum_o,
    output logic             cout_o
);

    logic [NIB_W-1:0] sum;
    logic             c;

    always_comb begin
        sum = '0;
        c   = cin_i;
        for (int k = 0; k < NIB_W; k++) begin
            sum[k] = a_i[k] ^ b_i[k] ^ c;
            c      = (a_i[k] & b_i[k]) | (c & (a_i[k] ^ b_i[k]));
        end
    end

    assign sum_o  = sum;
    assign cout_o = c;

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// Multi-nibble add/sub sequenced through one ripple_adder4, one nibble per clock.
// MAG_SIGN_OUT_EN: borrowing subtracts return |A-B| via an extra nibble-serial NEG pass.
module nibble_serial_alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     in_op_i,
    input  logic [NIB_W*NIBBLES-1:0] in_a_i,
    input  logic [NIB_W*NIBBLES-1:0] in_b_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [NIB_W*NIBBLES-1:0] out_result_o,
    output logic                     out_carry_o,
    output logic                     out_neg_o,
    output logic                     out_zero_o,
    output logic                     out_ovf_o
);

    localparam int         W        = NIB_W * NIBBLES;
    localparam logic [2:0] CNT_LAST = 3'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
    logic             op_q, op_d, c_q, c_d, fc_q, fc_d, ovf_q, ovf_d;
    logic [2:0]       cnt_q, cnt_d;

    logic [NIB_W-1:0] add_a, add_b, add_sum;
    logic             add_cin, add_cout;

    ripple_adder4 u_adder (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        c_d     = c_q;
        fc_d    = fc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        add_a   = a_q[NIB_W-1:0];
        add_b   = (op_q == OP_SUB) ? ~b_q[NIB_W-1:0] : b_q[NIB_W-1:0];
        add_cin = c_q;
`ifdef MAG_SIGN_OUT_EN
        if (state_q == ST_NEG) begin
            add_a = ~res_q[NIB_W-1:0];
            add_b = '0;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    a_d     = in_a_i;
                    b_d     = in_b_i;
                    op_d    = in_op_i;
                    c_d     = in_op_i;
                    cnt_d   = CNT_LAST;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                // operands shift down, result fills from the top nibble
                res_d = {add_sum, res_q[W-1:NIB_W]};
                a_d   = a_q >> NIB_W;
                b_d   = b_q >> NIB_W;
                c_d   = add_cout;
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    fc_d    = add_cout;
                    ovf_d   = (add_a[NIB_W-1] == add_b[NIB_W-1]) &&
                              (add_sum[NIB_W-1] != add_a[NIB_W-1]);
                    state_d = ST_DONE;
`ifdef MAG_SIGN_OUT_EN
                    if (op_q == OP_SUB && !add_cout) begin
                        c_d     = 1'b1;
                        cnt_d   = CNT_LAST;
                        state_d = ST_NEG;
                    end
`endif
                end
            end
`ifdef MAG_SIGN_OUT_EN
            ST_NEG: begin
                res_d = {add_sum, res_q[W-1:NIB_W]};
                c_d   = add_cout;
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            res_q   <= '0;
            c_q     <= 1'b0;
            fc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            c_q     <= c_d;
            fc_q    <= fc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // outputs are masked outside DONE so partial results never escape
    logic done;
    assign done         = (state_q == ST_DONE);
    assign in_ready_o   = (state_q == ST_IDLE);
    assign out_valid_o  = done;
    assign out_result_o = done ? res_q : '0;
    assign out_carry_o  = done & fc_q;
    assign out_neg_o    = done & (op_q == OP_SUB) & ~fc_q;
    assign out_zero_o   = done & (res_q == '0);
    assign out_ovf_o    = done & ovf_q;

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Self-checking bench: arithmetic reference model plus directed and random traffic.
module tb_nibble_serial_alu_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0, in_op = 1'b0, out_ready = 1'b1;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic         in_ready, out_valid, out_carry, out_neg, out_zero, out_ovf;
    logic [W-1:0] out_result;

    int errors = 0;
    int checks = 0;

    nibble_serial_alu_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_op_i      (in_op),
        .in_a_i       (in_a),
        .in_b_i       (in_b),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_result_o (out_result),
        .out_carry_o  (out_carry),
        .out_neg_o    (out_neg),
        .out_zero_o   (out_zero),
        .out_ovf_o    (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         carry, neg, zero, ovf;
        int           lat;
    } exp_t;

    // lat counts clock edges from the accept edge (inclusive) to out_valid visible
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        exp_t   e;
        longint ua = longint'(a), ub = longint'(b);
        longint md = longint'(1) << W;
        longint raw, sa, sb, sr;
        if (op) begin
            raw     = (ua - ub + md) % md;
            e.carry = (ua >= ub);
            e.neg   = (ua < ub);
        end else begin
            raw     = (ua + ub) % md;
            e.carry = ((ua + ub) >= md);
            e.neg   = 1'b0;
        end
        sa = (ua >= md / 2) ? ua - md : ua;
        sb = (ub >= md / 2) ? ub - md : ub;
        sr = op ? sa - sb : sa + sb;
        e.ovf = (sr >= md / 2) || (sr < -(md / 2));
        e.res = raw[W-1:0];
        e.lat = NIBBLES + 1;
`ifdef MAG_SIGN_OUT_EN
        if (e.neg) begin
            raw   = ub - ua;
            e.res = raw[W-1:0];
            e.lat = 2 * NIBBLES + 1;
        end
`endif
        e.zero = (e.res == '0);
        return e;
    endfunction

    // transaction-level view of the block: busy from accept until result handshake
    int   edge_n = 0;
    int   done_e = 0;
    bit   busy = 0;
    exp_t cur;

    always @(posedge clk) begin
        if (reset) begin
            busy = 0;
        end else if (!busy) begin
            if (in_valid) begin
                busy   = 1;
                cur    = model(in_a, in_b, in_op);
                done_e = edge_n + cur.lat;
            end
        end else if (edge_n >= done_e && out_ready) begin
            busy = 0;
        end
        edge_n = edge_n + 1;
    end

    always @(negedge clk) begin
        if (edge_n >= 1) begin
            logic         ev;
            logic [W-1:0] er;
            logic         ec, en, ez, eo;
            ev = busy && (edge_n >= done_e);
            er = ev ? cur.res : '0;
            ec = ev & cur.carry;
            en = ev & cur.neg;
            ez = ev & cur.zero;
            eo = ev & cur.ovf;
            checks++;
            if (in_ready !== !busy || out_valid !== ev || out_result !== er ||
                out_carry !== ec || out_neg !== en || out_zero !== ez || out_ovf !== eo) begin
                errors++;
                $display("FAIL cycle %0d: rdy=%b/%b vld=%b/%b res=%h/%h c=%b/%b n=%b/%b z=%b/%b o=%b/%b (got/exp)",
                         edge_n, in_ready, !busy, out_valid, ev, out_result, er,
                         out_carry, ec, out_neg, en, out_zero, ez, out_ovf, eo);
            end
        end
    end

    task automatic chk(input string nm, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("wait_in_ready", longint'(in_ready), 1);
    endtask

    // issue one request, measure latency, hold result for hold cycles with out_ready low
    task automatic issue(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic op, input int hold, output int lat_meas);
        int k;
        wait_ready();
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        k = 1;
        forever begin
            @(negedge clk);
            if (out_valid || k > 40) break;
            @(posedge clk);
            k++;
        end
        lat_meas = k;
        if (k > 40) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic op, input logic [W-1:0] r, input logic c,
                            input logic n, input logic z, input logic o, input int lat);
        exp_t m;
        int   lm;
        m = model(a, b, op);
        chk({nm, "_model_res"}, longint'(m.res), longint'(r));
        chk({nm, "_model_flags"}, longint'({m.carry, m.neg, m.zero, m.ovf}), longint'({c, n, z, o}));
        issue(nm, a, b, op, 0, lm);
        chk({nm, "_latency"}, lm, lat);
        chk({nm, "_result"}, longint'(out_result), longint'(r));
        chk({nm, "_flags"}, longint'({out_carry, out_neg, out_zero, out_ovf}), longint'({c, n, z, o}));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom % 6)
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int lm, seen;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_state", longint'({in_ready, out_valid, out_result, out_carry, out_neg, out_zero, out_ovf}),
            longint'({1'b1, 1'b0, 16'h0000, 4'b0000}));

        directed("add",      16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 5);
`ifdef MAG_SIGN_OUT_EN
        directed("sub_borrow", 16'h0003, 16'h0005, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0, 9);
`else
        directed("sub_borrow", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 5);
`endif
        directed("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        directed("sub_eq",   16'h5A5A, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 5);
        directed("sub_ovf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1, 5);

        // back-pressure: result must hold and a second request must be ignored
        issue("bp", 16'h1234, 16'h0FCD, 1'b0, 1, lm);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_a     = 16'hAAAA;
            in_b     = 16'h1111;
            in_op    = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("bp_in_ready", longint'(in_ready), 0);
            chk("bp_hold", longint'({out_valid, out_result}), longint'({1'b1, 16'h2201}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // reset while nibble 2 of the add is being processed
        wait_ready();
        in_valid = 1'b1;
        in_a     = 16'h1234;
        in_b     = 16'h0FCD;
        in_op    = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_state", longint'({in_ready, out_valid, out_result, out_carry, out_neg, out_zero, out_ovf}),
            longint'({1'b1, 1'b0, 16'h0000, 4'b0000}));
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_valid", seen, 0);

        // random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            reset     = ($urandom % 300) == 0;
            in_valid  = ($urandom % 2) == 0;
            in_op     = 1'($urandom);
            in_a      = pick();
            in_b      = pick();
            out_ready = ($urandom % 4) != 0;
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
